// File: rtl/fp_sched_pkg.sv
// Shared definitions for the fp_addsub_scheduler slice.
// Holds the scheduler FSM state type, the floating-point word width and a few
// IEEE-754 single-precision constants used by the design and its bench.
package fp_sched_pkg;

  localparam int FP_W = 32;

  // IEEE-754 single-precision constants
  localparam logic [FP_W-1:0] ONE   = 32'h3F80_0000;
  localparam logic [FP_W-1:0] TWO   = 32'h4000_0000;
  localparam logic [FP_W-1:0] THREE = 32'h4040_0000;
  localparam logic [FP_W-1:0] PINF  = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/Addition_Subtraction.sv
// Combinational single-precision add/sub unit shared by the scheduler.
// Ports:
//   a_operand, b_operand : IEEE-754 operands
//   AddBar_Sub           : 0 = a+b, 1 = a-b
//   Exception            : an operand exponent is 255; result is forced to 0
//   result               : IEEE-754 sum/difference (truncating, subnormals flush to 0)
module Addition_Subtraction (
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic        AddBar_Sub,
  output logic        Exception,
  output logic [31:0] result
);

  logic [31:0] b_eff_s;
  logic [31:0] big_s;
  logic [31:0] small_s;
  logic [24:0] mant_big_s;
  logic [24:0] mant_small_s;
  logic [24:0] sum_s;
  int          exp_s;
  int          shamt_s;
  int          msb_s;

  // Align, add/subtract magnitudes and renormalise
  always_comb begin
    Exception = (a_operand[30:23] == 8'hFF) || (b_operand[30:23] == 8'hFF);
    b_eff_s   = {b_operand[31] ^ AddBar_Sub, b_operand[30:0]};
    // Larger magnitude goes first so the subtraction never goes negative
    if (a_operand[30:0] >= b_eff_s[30:0]) begin
      big_s   = a_operand;
      small_s = b_eff_s;
    end else begin
      big_s   = b_eff_s;
      small_s = a_operand;
    end
    mant_big_s   = (big_s[30:23] == 8'd0)   ? 25'd0 : {2'b01, big_s[22:0]};
    mant_small_s = (small_s[30:23] == 8'd0) ? 25'd0 : {2'b01, small_s[22:0]};
    shamt_s      = int'(big_s[30:23]) - int'(small_s[30:23]);
    if (shamt_s > 24) begin
      mant_small_s = 25'd0;
    end else begin
      mant_small_s = mant_small_s >> shamt_s;
    end
    exp_s = int'(big_s[30:23]);
    if (big_s[31] == small_s[31]) begin
      sum_s = mant_big_s + mant_small_s;
    end else begin
      sum_s = mant_big_s - mant_small_s;
    end
    if (sum_s[24]) begin
      sum_s = sum_s >> 1;
      exp_s = exp_s + 1;
    end else begin
      sum_s = sum_s;
    end
    msb_s = -1;
    for (int i = 0; i < 24; i++) begin
      if (sum_s[i]) begin
        msb_s = i;
      end else begin
        msb_s = msb_s;
      end
    end
    result = 32'd0;
    if (msb_s >= 0) begin
      exp_s = exp_s - (23 - msb_s);
      sum_s = sum_s << (23 - msb_s);
      if (exp_s >= 255) begin
        result = {big_s[31], 8'hFF, 23'd0};
      end else if (exp_s > 0) begin
        result = {big_s[31], 8'(exp_s), sum_s[22:0]};
      end else begin
        result = 32'd0;
      end
    end else begin
      result = 32'd0;
    end
    if (Exception) begin
      result = 32'd0;
    end else begin
      result = result;
    end
  end

endmodule

// File: rtl/fp_addsub_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req_i       : request vector
//   ptr_i       : index with highest priority this round
//   grant_o     : one-hot grant (zero when no request)
//   grant_idx_o : encoded index of the granted request
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  grant_idx_o
);

  logic found_s;
  int   idx_s;

  // Scan from the pointer upward, wrapping modulo N_REQ; first hit wins
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found_s     = 1'b0;
    idx_s       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_s = (int'(ptr_i) + k) % N_REQ;
      if (!found_s && req_i[idx_s]) begin
        found_s        = 1'b1;
        grant_o[idx_s] = 1'b1;
        grant_idx_o    = ID_W'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/fp_addsub_scheduler.sv
// Shares one Addition_Subtraction datapath among N_REQ requesters.
// Round-robin grant in IDLE, one EXEC cycle on registered operands, then the
// tagged result is held in RESP until the consumer takes it.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   req_valid/a/b/sub   : per-requester operation requests (32-bit slices)
//   req_ready           : one-hot accept, only in IDLE
//   rsp_valid/ready     : response handshake
//   rsp_id/result/exception : tagged response payload
//   busy                : FSM not in IDLE
//   op_count            : saturating count of delivered responses
module fp_addsub_scheduler
  import fp_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*FP_W-1:0] req_a,
  input  logic [N_REQ*FP_W-1:0] req_b,
  input  logic [N_REQ-1:0]      req_sub,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [FP_W-1:0]       rsp_result,
  output logic                  rsp_exception,
  output logic                  busy,
  output logic [CNT_W-1:0]      op_count
);

  state_e          state_q;
  logic [ID_W-1:0] ptr_q;
  logic [FP_W-1:0] opa_q;
  logic [FP_W-1:0] opb_q;
  logic            sub_q;
  logic [ID_W-1:0] id_q;
  logic [CNT_W-1:0] op_count_q;
  logic [CNT_W-1:0] op_count_d;
  logic [ID_W-1:0] rsp_id_q;
  logic [FP_W-1:0] rsp_result_q;
  logic            rsp_exc_q;

  logic [N_REQ-1:0] grant_s;
  logic [ID_W-1:0]  grant_idx_s;
  logic [FP_W-1:0]  dp_result_s;
  logic             dp_exc_s;
  logic             accept_s;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (grant_s),
    .grant_idx_o (grant_idx_s)
  );

  Addition_Subtraction u_dp (
    .a_operand  (opa_q),
    .b_operand  (opb_q),
    .AddBar_Sub (sub_q),
    .Exception  (dp_exc_s),
    .result     (dp_result_s)
  );

  // Grant is only offered in IDLE; rst_n gating keeps req_ready at 0 during reset
  always_comb begin
    if (rst_n && (state_q == IDLE)) begin
      req_ready = grant_s;
    end else begin
      req_ready = '0;
    end
    accept_s = |req_ready;
  end

  // Saturating increment of the delivered-response counter
  always_comb begin
    if (op_count_q != {CNT_W{1'b1}}) begin
      op_count_d = op_count_q + CNT_W'(1);
    end else begin
      op_count_d = op_count_q;
    end
  end

  // Scheduler FSM, operand capture and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      sub_q        <= 1'b0;
      id_q         <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_exc_q    <= 1'b0;
      op_count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            opa_q   <= req_a[FP_W*grant_idx_s +: FP_W];
            opb_q   <= req_b[FP_W*grant_idx_s +: FP_W];
            sub_q   <= req_sub[grant_idx_s];
            id_q    <= grant_idx_s;
            ptr_q   <= (int'(grant_idx_s) == N_REQ-1) ? '0 : grant_idx_s + ID_W'(1);
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= dp_result_s;
          rsp_exc_q    <= dp_exc_s;
          rsp_id_q     <= id_q;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            op_count_q <= op_count_d;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid     = (state_q == RESP);
  assign busy          = (state_q != IDLE);
  assign rsp_id        = rsp_id_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_exception = rsp_exc_q;
  assign op_count      = op_count_q;

endmodule

// File: tb/tb_fp_addsub_scheduler.sv
// Directed, table-driven bench for fp_addsub_scheduler with hand-written
// sequences for round-robin order, backpressure and reset during EXEC.
module tb_fp_addsub_scheduler;
  import fp_sched_pkg::*;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*32-1:0]   req_a;
  logic [N_REQ*32-1:0]   req_b;
  logic [N_REQ-1:0]      req_sub;
  logic [N_REQ-1:0]      req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_result;
  logic                  rsp_exception;
  logic                  busy;
  logic [CNT_W-1:0]      op_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  vec_t vecs[6];

  fp_addsub_scheduler #(.N_REQ(N_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_sub       (req_sub),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_result    (rsp_result),
    .rsp_exception (rsp_exception),
    .busy          (busy),
    .op_count      (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    chk({tag, "_rsp_result"}, rsp_result, 32'd0);
    chk({tag, "_rsp_exc"}, 32'(rsp_exception), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_op_count"}, 32'(op_count), 32'd0);
  endtask

  // Called at a negedge in IDLE; returns at a negedge back in IDLE
  task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic [31:0] er, input logic ee);
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    req_sub[id]        = sub;
    req_valid          = '0;
    req_valid[id]      = 1'b1;
    rsp_ready          = 1'b1;
    #1;
    chk("op_grant", 32'(req_ready), 32'(1) << id);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    chk("op_exec_busy", 32'(busy), 32'd1);
    chk("op_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("op_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("op_rsp_id", 32'(rsp_id), 32'(id));
    chk("op_rsp_result", rsp_result, er);
    chk("op_rsp_exc", 32'(rsp_exception), 32'(ee));
    chk("op_rsp_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    exp_count++;
    chk("op_count", 32'(op_count), 32'(exp_count));
    chk("op_done_rsp_valid", 32'(rsp_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
  endtask

  int acc_id[5];
  int acc_cyc[5];
  int n_acc;
  int last_id;
  int gidx;
  int wait_cnt;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b0;

    vecs[0] = '{id: 0, a: ONE,   b: TWO,  sub: 1'b0, res: THREE,        exc: 1'b0};
    vecs[1] = '{id: 2, a: THREE, b: ONE,  sub: 1'b1, res: TWO,          exc: 1'b0};
    vecs[2] = '{id: 1, a: PINF,  b: ONE,  sub: 1'b0, res: 32'h0000_0000, exc: 1'b1};
    vecs[3] = '{id: 3, a: TWO,   b: TWO,  sub: 1'b1, res: 32'h0000_0000, exc: 1'b0};
    vecs[4] = '{id: 0, a: ONE,   b: THREE, sub: 1'b1, res: 32'hC000_0000, exc: 1'b0};
    vecs[5] = '{id: 1, a: ONE,   b: ONE,  sub: 1'b0, res: TWO,          exc: 1'b0};

    // Power-on reset values
    @(negedge clk);
    chk_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      do_op(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].sub, vecs[v].res, vecs[v].exc);
    end

    // Round-robin with every requester continuously valid
    do_reset();
    for (int i = 0; i < N_REQ; i++) begin
      req_a[32*i +: 32] = ONE;
      req_b[32*i +: 32] = ONE;
      req_sub[i]        = 1'b0;
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    n_acc   = 0;
    last_id = -1;
    for (int c = 0; c < 40 && n_acc < 5; c++) begin
      #1;
      if (rsp_valid) begin
        chk("rr_rsp_id", 32'(rsp_id), 32'(last_id));
        chk("rr_rsp_result", rsp_result, TWO);
      end
      if (req_ready != '0) begin
        gidx = 0;
        for (int j = 0; j < N_REQ; j++) if (req_ready[j]) gidx = j;
        acc_id[n_acc]  = gidx;
        acc_cyc[n_acc] = c;
        last_id        = gidx;
        n_acc++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    chk("rr_accepts", 32'(n_acc), 32'd5);
    for (int k = 0; k < n_acc; k++) begin
      chk("rr_order", 32'(acc_id[k]), 32'(k % N_REQ));
      if (k > 0) chk("rr_gap", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd3);
    end
    wait_cnt = 0;
    while (busy && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("rr_drain_busy", 32'(busy), 32'd0);
    exp_count = 5;
    chk("rr_op_count", 32'(op_count), 32'(exp_count));

    // Backpressure: pointer now 1
    req_a[32 +: 32] = ONE;
    req_b[32 +: 32] = TWO;
    req_sub[1]      = 1'b0;
    req_valid       = 4'b0010;
    rsp_ready       = 1'b0;
    #1;
    chk("bp_grant", 32'(req_ready), 32'h2);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    req_a[96 +: 32] = ONE;
    req_b[96 +: 32] = ONE;
    req_sub[3]      = 1'b0;
    req_valid       = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_id", 32'(rsp_id), 32'd1);
      chk("bp_rsp_result", rsp_result, THREE);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_hs_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    exp_count++;
    chk("bp_after_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("bp_after_grant", 32'(req_ready), 32'h8);
    chk("bp_op_count", 32'(op_count), 32'(exp_count));
    do_op(3, ONE, ONE, 1'b0, TWO, 1'b0);

    // Reset while EXEC: pointer now 0
    req_valid = 4'b1000;
    #1;
    chk("rx_grant", 32'(req_ready), 32'h8);
    @(posedge clk);
    @(negedge clk);
    chk("rx_in_exec", 32'(busy), 32'd1);
    rst_n = 1'b0;
    req_a[0 +: 32] = ONE;
    req_b[0 +: 32] = TWO;
    req_sub[0]     = 1'b0;
    req_valid      = 4'b1001;
    #1;
    chk_reset_vals("rx");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
    #1;
    chk("rx_tie_grant", 32'(req_ready), 32'h1);
    chk("rx_no_stale", 32'(rsp_valid), 32'd0);
    do_op(0, ONE, TWO, 1'b0, THREE, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
